apb_protocol_monitor: RTL and testbench

- Synthesizable, passive APB4/APB5 bus monitor on a single requester/multi-completer segment, parametrised in width and PSEL count.
- Tracks each transfer with an FSM and flags protocol violations in sticky per-class error bits, plus an error pulse.
- Keeps saturating transfer and error counters and a PREADY timeout watchdog.
- Outputs feed a status register block and system interrupt logic. It never drives the bus.

---
 rtl/apb_protocol_monitor.sv | 242 ++++++++++++++++++++++++
 tb/tb_apb_protocol_monitor.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_protocol_monitor.sv
// rtl/apb_protocol_monitor.sv - passive APB4/APB5 protocol monitor (optional per-PSEL counters: APB_MON_SEL_CNT_EN)
module apb_protocol_monitor #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SEL        = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic [ADDR_WIDTH-1:0]        PADDR,
    input  logic [2:0]                   PPROT,
    input  logic [NUM_SEL-1:0]           PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [DATA_WIDTH-1:0]        PWDATA,
    input  logic [DATA_WIDTH/8-1:0]      PSTRB,
    input  logic                         PREADY,
    input  logic [DATA_WIDTH-1:0]        PRDATA,
    input  logic                         PSLVERR,
    input  logic                         clr_i,
    output logic [7:0]                   err_flags_o,
    output logic                         err_pulse_o,
    output logic [CNT_WIDTH-1:0]         err_count_o,
    output logic [CNT_WIDTH-1:0]         xfer_count_o,
    output logic                         timeout_o,
    output logic [NUM_SEL*CNT_WIDTH-1:0] sel_xfer_cnt_o
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // Violation flag positions
    localparam int F_MULTI_SEL = 0;
    localparam int F_SEQ       = 1;
    localparam int F_STABLE    = 2;
    localparam int F_WDATA     = 3;
    localparam int F_READ_STRB = 4;
    localparam int F_TIMEOUT   = 5;
    localparam int F_DROP      = 6;
    localparam int F_SLVERR    = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic [NUM_SEL-1:0]      cap_sel;
    logic [ADDR_WIDTH-1:0]   cap_addr;
    logic [2:0]              cap_prot;
    logic                    cap_write;
    logic [STRB_WIDTH-1:0]   cap_strb;
    logic [DATA_WIDTH-1:0]   cap_wdata;

    logic [CNT_WIDTH-1:0]    wait_cnt;
    logic [CNT_WIDTH-1:0]    wait_nxt;
    logic                    timeout_seen;

    logic                    smp_idle;
    logic                    smp_setup;
    logic                    smp_access;
    logic                    capture;
    logic                    complete;
    logic                    wd_fire;
    logic [7:0]              viol;

    // PRDATA is carried on the port for future parity checking only
    logic                    unused_prdata;
    assign unused_prdata = ^PRDATA;

    // Sample classification from the current bus values
    always_comb begin
        smp_idle   = (PSEL == '0);
        smp_setup  = !smp_idle && !PENABLE;
        smp_access = !smp_idle && PENABLE;
    end

    // Decode the next phase and every violation implied by this sample
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        complete  = 1'b0;
        wait_nxt  = '0;
        viol      = '0;
        wd_fire   = 1'b0;

        viol[F_MULTI_SEL] = ($countones(PSEL) > 1);
        viol[F_READ_STRB] = !PWRITE && (PSTRB != '0) && !smp_idle;

        case (state)
            ST_IDLE: begin
                if (smp_setup) begin
                    state_nxt = ST_SETUP;
                    capture   = 1'b1;
                end else if (PENABLE) begin
                    // access without setup, or PENABLE with nothing selected
                    viol[F_SEQ] = 1'b1;
                end
            end
            ST_SETUP: begin
                if (smp_access) begin
                    if (PREADY) begin
                        complete  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_WAIT;
                        wait_nxt  = CNT_WIDTH'(1);
                    end
                end else if (smp_idle) begin
                    viol[F_SEQ] = 1'b1;
                    state_nxt   = ST_IDLE;
                end else begin
                    viol[F_SEQ] = 1'b1;
                    capture     = 1'b1;
                end
            end
            ST_WAIT: begin
                if (smp_access) begin
                    if (PREADY) begin
                        complete  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        wait_nxt = (wait_cnt == '1) ? wait_cnt : wait_cnt + CNT_WIDTH'(1);
                    end
                end else if (smp_idle) begin
                    viol[F_DROP] = 1'b1;
                    state_nxt    = ST_IDLE;
                end else begin
                    viol[F_SEQ] = 1'b1;
                    capture     = 1'b1;
                    state_nxt   = ST_SETUP;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Control and write data must hold from setup through the end of the access phase
        if (smp_access && (state != ST_IDLE)) begin
            viol[F_STABLE] = (PSEL != cap_sel) || (PADDR != cap_addr) || (PPROT != cap_prot) ||
                             (PWRITE != cap_write) || (PSTRB != cap_strb);
            viol[F_WDATA]  = cap_write && (PWDATA != cap_wdata);
        end

        // Watchdog fires once per transfer, the first time the wait length reaches the limit
        wd_fire = (TIMEOUT_CYCLES != 0) && (state_nxt == ST_WAIT) && !timeout_seen &&
                  (32'(wait_nxt) >= 32'(TIMEOUT_CYCLES));
        viol[F_TIMEOUT] = wd_fire;
        viol[F_SLVERR]  = complete && PSLVERR;
    end

    // Phase tracker: previous phase, captured setup fields, wait length and watchdog one-shot
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state        <= ST_IDLE;
            cap_sel      <= '0;
            cap_addr     <= '0;
            cap_prot     <= '0;
            cap_write    <= 1'b0;
            cap_strb     <= '0;
            cap_wdata    <= '0;
            wait_cnt     <= '0;
            timeout_seen <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                cap_sel   <= PSEL;
                cap_addr  <= PADDR;
                cap_prot  <= PPROT;
                cap_write <= PWRITE;
                cap_strb  <= PSTRB;
                cap_wdata <= PWDATA;
            end
            wait_cnt     <= wait_nxt;
            timeout_seen <= (state_nxt == ST_WAIT) && (timeout_seen || wd_fire);
        end
    end

    // Status outputs: sticky flags, pulse, saturating counters and timeout indication
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            err_flags_o  <= '0;
            err_pulse_o  <= 1'b0;
            err_count_o  <= '0;
            xfer_count_o <= '0;
            timeout_o    <= 1'b0;
        end else if (clr_i) begin
            err_flags_o  <= '0;
            err_pulse_o  <= 1'b0;
            err_count_o  <= '0;
            xfer_count_o <= '0;
            timeout_o    <= 1'b0;
        end else begin
            err_flags_o <= err_flags_o | viol;
            err_pulse_o <= |viol;
            if ((|viol) && (err_count_o != '1)) begin
                err_count_o <= err_count_o + CNT_WIDTH'(1);
            end
            if (complete && (xfer_count_o != '1)) begin
                xfer_count_o <= xfer_count_o + CNT_WIDTH'(1);
            end
            timeout_o <= (state_nxt == ST_WAIT) && (timeout_o || wd_fire);
        end
    end

`ifdef APB_MON_SEL_CNT_EN
    localparam int IDX_W = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1;

    logic [NUM_SEL-1:0][CNT_WIDTH-1:0] sel_cnt;
    logic [IDX_W-1:0]                  sel_low;

    // Completer index of a transfer is the lowest set bit of its captured PSEL
    always_comb begin
        sel_low = '0;
        for (int i = NUM_SEL - 1; i >= 0; i--) begin
            if (cap_sel[i]) begin
                sel_low = IDX_W'(i);
            end
        end
    end

    // Per-completer saturating transfer counters
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sel_cnt <= '0;
        end else if (clr_i) begin
            sel_cnt <= '0;
        end else if (complete && (sel_cnt[sel_low] != '1)) begin
            sel_cnt[sel_low] <= sel_cnt[sel_low] + CNT_WIDTH'(1);
        end
    end

    assign sel_xfer_cnt_o = sel_cnt;
`else
    assign sel_xfer_cnt_o = '0;
`endif

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// tb/tb_apb_protocol_monitor.sv - self-checking bench for apb_protocol_monitor
module tb_apb_protocol_monitor;

    localparam int TO = 16;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [31:0] PADDR;
    logic [2:0]  PPROT;
    logic [3:0]  PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;
    logic        clr_i;
    logic [7:0]  err_flags_o;
    logic        err_pulse_o;
    logic [15:0] err_count_o;
    logic [15:0] xfer_count_o;
    logic        timeout_o;
    logic [63:0] sel_xfer_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 PCLK = ~PCLK;

    apb_protocol_monitor #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SEL(4), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(16)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PPROT(PPROT), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR), .clr_i(clr_i),
        .err_flags_o(err_flags_o), .err_pulse_o(err_pulse_o), .err_count_o(err_count_o),
        .xfer_count_o(xfer_count_o), .timeout_o(timeout_o), .sel_xfer_cnt_o(sel_xfer_cnt_o)
    );

    // Reference model: open-transfer length plus captured fields, bus rules applied directly
    int          m_open;   // 0: no transfer, 1: setup seen, n>=2: n-1 wait samples so far
    logic [3:0]  c_sel, c_strb;
    logic [31:0] c_addr, c_wdata;
    logic [2:0]  c_prot;
    logic        c_wr;
    logic [7:0]  m_flags;
    logic        m_pulse, m_to;
    int          m_err, m_xfer;
    int          m_selc[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_open = 0;
        c_sel = 0; c_strb = 0; c_addr = 0; c_wdata = 0; c_prot = 0; c_wr = 0;
        m_flags = 0; m_pulse = 0; m_to = 0; m_err = 0; m_xfer = 0;
        for (int i = 0; i < 4; i++) m_selc[i] = 0;
    endtask

    task automatic capture_fields();
        c_sel = PSEL; c_addr = PADDR; c_prot = PPROT; c_wr = PWRITE; c_strb = PSTRB; c_wdata = PWDATA;
    endtask

    task automatic model_step();
        logic [7:0] v;
        logic       is_idle, is_setup, is_access, done, fire;
        int         lo;
        if (!PRESETn) begin
            model_reset();
            return;
        end
        v = 8'h00;
        done = 1'b0;
        is_idle   = (PSEL == 4'h0);
        is_setup  = !is_idle && !PENABLE;
        is_access = !is_idle && PENABLE;
        if ($countones(PSEL) > 1) v[0] = 1'b1;
        if (!PWRITE && PSTRB != 4'h0 && !is_idle) v[4] = 1'b1;
        if (m_open == 0) begin
            if (PENABLE) v[1] = 1'b1;
            if (is_setup) begin m_open = 1; capture_fields(); end
        end else if (is_access) begin
            if (PSEL != c_sel || PADDR != c_addr || PPROT != c_prot || PWRITE != c_wr || PSTRB != c_strb) v[2] = 1'b1;
            if (c_wr && PWDATA != c_wdata) v[3] = 1'b1;
            if (PREADY) begin done = 1'b1; m_open = 0; end
            else m_open = m_open + 1;
        end else if (is_idle) begin
            if (m_open == 1) v[1] = 1'b1; else v[6] = 1'b1;
            m_open = 0;
        end else begin
            v[1] = 1'b1;
            m_open = 1;
            capture_fields();
        end
        if (done && PSLVERR) v[7] = 1'b1;
        fire = (TO > 0) && (m_open - 1 == TO);
        v[5] = fire;
        if (clr_i) begin
            m_flags = 0; m_pulse = 0; m_err = 0; m_xfer = 0; m_to = 0;
            for (int i = 0; i < 4; i++) m_selc[i] = 0;
        end else begin
            m_flags = m_flags | v;
            m_pulse = (v != 0);
            if (v != 0 && m_err < 65535) m_err++;
            if (done && m_xfer < 65535) m_xfer++;
            if (done) begin
                lo = 0;
                for (int i = 3; i >= 0; i--) if (c_sel[i]) lo = i;
                if (m_selc[lo] < 65535) m_selc[lo]++;
            end
            m_to = (m_open >= 2) && (m_to || fire);
        end
    endtask

    function automatic logic [63:0] exp_sel();
        logic [63:0] r;
        r = 64'h0;
`ifdef APB_MON_SEL_CNT_EN
        for (int i = 0; i < 4; i++) r[i*16 +: 16] = 16'(m_selc[i]);
`endif
        return r;
    endfunction

    task automatic compare_model(input string tag);
        check({tag, " flags"},   64'(err_flags_o),  64'(m_flags));
        check({tag, " pulse"},   64'(err_pulse_o),  64'(m_pulse));
        check({tag, " errcnt"},  64'(err_count_o),  64'(m_err));
        check({tag, " xfercnt"}, 64'(xfer_count_o), 64'(m_xfer));
        check({tag, " timeout"}, 64'(timeout_o),    64'(m_to));
        check({tag, " selcnt"},  sel_xfer_cnt_o,    exp_sel());
    endtask

    // One bus sample: drive, clock, let the model see the same sample, leave outputs settled
    task automatic apply(input logic [3:0] sel, input logic pen, input logic [31:0] a, input logic w,
                         input logic [3:0] s, input logic [31:0] d, input logic [2:0] pr,
                         input logic rdy, input logic err, input logic clr);
        PSEL = sel; PENABLE = pen; PADDR = a; PWRITE = w; PSTRB = s; PWDATA = d; PPROT = pr;
        PREADY = rdy; PSLVERR = err; clr_i = clr;
        @(posedge PCLK);
        #1;
        model_step();
    endtask

    typedef struct {
        logic [3:0]  sel;
        logic        pen;
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic        rdy;
        logic        slverr;
        logic        clr;
        logic [7:0]  e_flags;
        logic        e_pulse;
        logic [15:0] e_xfer;
        logic [15:0] e_err;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] sel, input logic pen, input logic [31:0] addr,
                                input logic wr, input logic [3:0] strb, input logic [31:0] wdata,
                                input logic rdy, input logic slverr, input logic clr,
                                input logic [7:0] ef, input logic ep, input logic [15:0] ex,
                                input logic [15:0] ee);
        vec_t r;
        r.sel = sel; r.pen = pen; r.addr = addr; r.wr = wr; r.strb = strb; r.wdata = wdata;
        r.rdy = rdy; r.slverr = slverr; r.clr = clr;
        r.e_flags = ef; r.e_pulse = ep; r.e_xfer = ex; r.e_err = ee;
        return r;
    endfunction

    vec_t tbl[$];

    initial begin
        logic [3:0]  sel, s;
        logic [31:0] a, d;
        logic [2:0]  pr;
        logic        w, pen_l, hold;
        int          exp_slice[4];

        PRESETn = 1'b0; PSEL = 0; PENABLE = 0; PADDR = 0; PWRITE = 0; PSTRB = 0; PWDATA = 0;
        PPROT = 0; PREADY = 0; PRDATA = 32'h5A5A_0000; PSLVERR = 0; clr_i = 0;
        model_reset();
        @(posedge PCLK);
        #1;
        check("reset flags",   64'(err_flags_o),  64'h0);
        check("reset pulse",   64'(err_pulse_o),  64'h0);
        check("reset errcnt",  64'(err_count_o),  64'h0);
        check("reset xfercnt", 64'(xfer_count_o), 64'h0);
        check("reset timeout", 64'(timeout_o),    64'h0);
        check("reset selcnt",  sel_xfer_cnt_o,    64'h0);
        @(negedge PCLK);
        PRESETn = 1'b1;

        //            sel   pen addr          wr strb  wdata   rdy err clr   flags pulse xfer err
        tbl.push_back(mk(4'h0, 0, 32'h000, 0, 4'h0, 32'h00, 0, 0, 0,  8'h00, 0, 0, 0));
        tbl.push_back(mk(4'h2, 0, 32'h100, 1, 4'hF, 32'hA5, 0, 0, 0,  8'h00, 0, 0, 0));
        tbl.push_back(mk(4'h2, 1, 32'h100, 1, 4'hF, 32'hA5, 1, 0, 0,  8'h00, 0, 1, 0));
        tbl.push_back(mk(4'h0, 0, 32'h000, 0, 4'h0, 32'h00, 0, 0, 0,  8'h00, 0, 1, 0));
        tbl.push_back(mk(4'h0, 0, 32'h000, 0, 4'h0, 32'h00, 0, 0, 1,  8'h00, 0, 0, 0));
        tbl.push_back(mk(4'h1, 0, 32'h200, 0, 4'h3, 32'h00, 0, 0, 0,  8'h10, 1, 0, 1));
        tbl.push_back(mk(4'h1, 1, 32'h200, 0, 4'h3, 32'h00, 0, 0, 0,  8'h10, 1, 0, 2));
        tbl.push_back(mk(4'h1, 1, 32'h200, 0, 4'h3, 32'h00, 0, 0, 0,  8'h10, 1, 0, 3));
        tbl.push_back(mk(4'h1, 1, 32'h200, 0, 4'h3, 32'h00, 1, 0, 0,  8'h10, 1, 1, 4));
        tbl.push_back(mk(4'h0, 0, 32'h000, 0, 4'h0, 32'h00, 0, 0, 0,  8'h10, 0, 1, 4));
        tbl.push_back(mk(4'h0, 0, 32'h000, 0, 4'h0, 32'h00, 0, 0, 1,  8'h00, 0, 0, 0));
        tbl.push_back(mk(4'h2, 0, 32'h100, 1, 4'hF, 32'hA5, 0, 0, 0,  8'h00, 0, 0, 0));
        tbl.push_back(mk(4'h2, 1, 32'h104, 1, 4'hF, 32'hA5, 1, 0, 0,  8'h04, 1, 1, 1));
        tbl.push_back(mk(4'h0, 0, 32'h000, 0, 4'h0, 32'h00, 0, 0, 0,  8'h04, 0, 1, 1));
        tbl.push_back(mk(4'h0, 0, 32'h000, 0, 4'h0, 32'h00, 0, 0, 1,  8'h00, 0, 0, 0));
        tbl.push_back(mk(4'h3, 0, 32'h100, 1, 4'hF, 32'hA5, 0, 0, 0,  8'h01, 1, 0, 1));
        tbl.push_back(mk(4'h3, 1, 32'h100, 1, 4'hF, 32'hA5, 1, 0, 0,  8'h01, 1, 1, 2));
        tbl.push_back(mk(4'h0, 1, 32'h000, 1, 4'h0, 32'h00, 0, 0, 0,  8'h03, 1, 1, 3));
        tbl.push_back(mk(4'h0, 0, 32'h000, 0, 4'h0, 32'h00, 0, 0, 0,  8'h03, 0, 1, 3));
        tbl.push_back(mk(4'h0, 0, 32'h000, 0, 4'h0, 32'h00, 0, 0, 1,  8'h00, 0, 0, 0));
        tbl.push_back(mk(4'h4, 0, 32'h300, 1, 4'hF, 32'hA5, 0, 0, 0,  8'h00, 0, 0, 0));
        tbl.push_back(mk(4'h4, 1, 32'h300, 1, 4'hF, 32'hA5, 0, 0, 0,  8'h00, 0, 0, 0));
        tbl.push_back(mk(4'h0, 0, 32'h000, 0, 4'h0, 32'h00, 0, 0, 0,  8'h40, 1, 0, 1));
        tbl.push_back(mk(4'h4, 0, 32'h300, 1, 4'hF, 32'hA5, 0, 0, 0,  8'h40, 0, 0, 1));
        tbl.push_back(mk(4'h4, 1, 32'h300, 1, 4'hF, 32'hA5, 1, 1, 0,  8'hC0, 1, 1, 2));
        tbl.push_back(mk(4'h0, 0, 32'h000, 0, 4'h0, 32'h00, 0, 0, 0,  8'hC0, 0, 1, 2));
        tbl.push_back(mk(4'h1, 0, 32'h400, 1, 4'hF, 32'h11, 0, 0, 0,  8'hC0, 0, 1, 2));
        tbl.push_back(mk(4'h1, 1, 32'h400, 1, 4'hF, 32'h22, 1, 0, 0,  8'hC8, 1, 2, 3));
        tbl.push_back(mk(4'h0, 0, 32'h000, 0, 4'h0, 32'h00, 0, 0, 0,  8'hC8, 0, 2, 3));

        foreach (tbl[i]) begin
            apply(tbl[i].sel, tbl[i].pen, tbl[i].addr, tbl[i].wr, tbl[i].strb, tbl[i].wdata, 3'h0,
                  tbl[i].rdy, tbl[i].slverr, tbl[i].clr);
            check($sformatf("vec%0d flags", i),   64'(err_flags_o),  64'(tbl[i].e_flags));
            check($sformatf("vec%0d pulse", i),   64'(err_pulse_o),  64'(tbl[i].e_pulse));
            check($sformatf("vec%0d xfercnt", i), 64'(xfer_count_o), 64'(tbl[i].e_xfer));
            check($sformatf("vec%0d errcnt", i),  64'(err_count_o),  64'(tbl[i].e_err));
            check($sformatf("vec%0d timeout", i), 64'(timeout_o),    64'h0);
        end

        // Watchdog: 20 wait samples, limit reached on the 16th
        apply(4'h0, 0, 32'h0, 0, 4'h0, 32'h0, 3'h0, 0, 0, 1);
        apply(4'h1, 0, 32'h500, 1, 4'hF, 32'h77, 3'h2, 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            apply(4'h1, 1, 32'h500, 1, 4'hF, 32'h77, 3'h2, 0, 0, 0);
            check($sformatf("wd wait%0d timeout", k), 64'(timeout_o), 64'(k >= TO));
            check($sformatf("wd wait%0d bit5", k), 64'(err_flags_o[5]), 64'(k >= TO));
            check($sformatf("wd wait%0d pulse", k), 64'(err_pulse_o), 64'(k == TO));
        end
        apply(4'h1, 1, 32'h500, 1, 4'hF, 32'h77, 3'h2, 1, 0, 0);
        check("wd done timeout", 64'(timeout_o),    64'h0);
        check("wd done xfercnt", 64'(xfer_count_o), 64'h1);
        check("wd done flags",   64'(err_flags_o),  64'h20);
        check("wd done errcnt",  64'(err_count_o),  64'h1);

        // Reset in the middle of a waited read that is already flagging
        apply(4'h2, 0, 32'h600, 0, 4'h1, 32'h0, 3'h0, 0, 0, 0);
        apply(4'h2, 1, 32'h600, 0, 4'h1, 32'h0, 3'h0, 0, 0, 0);
        apply(4'h2, 1, 32'h600, 0, 4'h1, 32'h0, 3'h0, 0, 0, 0);
        check("prerst flags nonzero", 64'(err_flags_o != 0), 64'h1);
        #2;
        PRESETn = 1'b0;
        #1;
        check("midrst flags",   64'(err_flags_o),  64'h0);
        check("midrst pulse",   64'(err_pulse_o),  64'h0);
        check("midrst errcnt",  64'(err_count_o),  64'h0);
        check("midrst xfercnt", 64'(xfer_count_o), 64'h0);
        check("midrst timeout", 64'(timeout_o),    64'h0);
        check("midrst selcnt",  sel_xfer_cnt_o,    64'h0);
        model_reset();
        apply(4'h0, 0, 32'h0, 0, 4'h0, 32'h0, 3'h0, 0, 0, 0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        apply(4'h1, 0, 32'h700, 1, 4'hF, 32'h33, 3'h0, 0, 0, 0);
        apply(4'h1, 1, 32'h700, 1, 4'hF, 32'h33, 3'h0, 1, 0, 0);
        apply(4'h0, 0, 32'h0, 0, 4'h0, 32'h0, 3'h0, 0, 0, 0);
        check("postrst xfercnt", 64'(xfer_count_o), 64'h1);
        check("postrst flags",   64'(err_flags_o),  64'h0);
        check("postrst errcnt",  64'(err_count_o),  64'h0);

        // Per-completer counts: three to PSEL[2], one to PSEL[0]
        apply(4'h0, 0, 32'h0, 0, 4'h0, 32'h0, 3'h0, 0, 0, 1);
        for (int t = 0; t < 4; t++) begin
            sel = (t < 3) ? 4'h4 : 4'h1;
            apply(sel, 0, 32'h800, 1, 4'hF, 32'h44, 3'h0, 0, 0, 0);
            apply(sel, 1, 32'h800, 1, 4'hF, 32'h44, 3'h0, 1, 0, 0);
        end
        apply(4'h0, 0, 32'h0, 0, 4'h0, 32'h0, 3'h0, 0, 0, 0);
        exp_slice[0] = 0; exp_slice[1] = 0; exp_slice[2] = 0; exp_slice[3] = 0;
`ifdef APB_MON_SEL_CNT_EN
        exp_slice[0] = 1; exp_slice[2] = 3;
`endif
        for (int i = 0; i < 4; i++)
            check($sformatf("sel slice%0d", i), 64'(sel_xfer_cnt_o[i*16 +: 16]), 64'(exp_slice[i]));
        check("sel xfercnt", 64'(xfer_count_o), 64'h4);

        // Randomized traffic, mostly protocol-shaped with occasional corruption
        for (int n = 0; n < 3000; n++) begin
            hold = (PSEL != 4'h0) && (!PENABLE || !PREADY);
            if ($urandom_range(99) < 85) begin
                if (hold) begin
                    sel = PSEL; a = PADDR; w = PWRITE; s = PSTRB; d = PWDATA; pr = PPROT; pen_l = 1'b1;
                end else if ($urandom_range(2) == 0) begin
                    sel = 4'h0; pen_l = 1'b0; a = $urandom; w = 1'($urandom_range(1));
                    s = 4'h0; d = $urandom; pr = 3'($urandom_range(7));
                end else begin
                    sel = 4'(1 << $urandom_range(3)); pen_l = 1'b0;
                    a = 32'h100 + 32'(4 * $urandom_range(3)); w = 1'($urandom_range(1));
                    s = w ? 4'hF : (($urandom_range(9) == 0) ? 4'h1 : 4'h0);
                    d = $urandom; pr = 3'($urandom_range(7));
                end
            end else begin
                sel = 4'($urandom_range(15)); pen_l = 1'($urandom_range(1));
                a = 32'h100 + 32'(4 * $urandom_range(3)); w = 1'($urandom_range(1));
                s = 4'($urandom_range(15)); d = 32'($urandom_range(3)); pr = 3'($urandom_range(7));
            end
            apply(sel, pen_l, a, w, s, d, pr, 1'($urandom_range(99) < 65),
                  1'($urandom_range(9) == 0), 1'($urandom_range(49) == 0));
            compare_model($sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
